// File: rtl/rffp_sched_pkg.sv
// Shared types for the RFFP->FP conversion scheduler.
package rffp_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Default-configuration widths (4 requesters, RFFP {1,8,8} -> FP {1,8,7}).
  localparam int NUM_REQ_D      = 4;
  localparam int EXP_WIDTH_D    = 8;
  localparam int MAN_WIDTH_D    = 7;
  localparam int RFFP_EXP_W_D   = 8;
  localparam int RFFP_MAN_W_D   = 8;

  localparam int RFFP_W = 1 + RFFP_EXP_W_D + RFFP_MAN_W_D;
  localparam int FP_W   = 1 + EXP_WIDTH_D + MAN_WIDTH_D;
  localparam int ID_W   = $clog2(NUM_REQ_D);

  // S1 holds the raw word plus its source; S2 holds the converted word.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RFFP_W-1:0] rffp;
  } s1_entry_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [FP_W-1:0] fp;
    logic            zero;
  } s2_entry_t;

endpackage

// File: rtl/rffp_fp_conv.sv
// Combinational RFFP->FP conversion core: sign passthrough, exponent
// rebias by leading-zero count, mantissa truncated (never normalised).
module rffp_fp_conv #(
  parameter int EXP_WIDTH      = 8,
  parameter int MAN_WIDTH      = 7,
  parameter int RFFP_EXP_WIDTH = 8,
  parameter int RFFP_MAN_WIDTH = 8
) (
  input  logic [RFFP_EXP_WIDTH+RFFP_MAN_WIDTH:0] rffp,
  output logic [EXP_WIDTH+MAN_WIDTH:0]           fp,
  output logic                                   zero
);

  logic                      sign;
  logic [RFFP_EXP_WIDTH-1:0] exp_in;
  logic [RFFP_MAN_WIDTH-1:0] man;
  logic [EXP_WIDTH-1:0]      exp_out;
  int                        lzc;
  int                        exp_calc;

  assign sign   = rffp[RFFP_EXP_WIDTH+RFFP_MAN_WIDTH];
  assign exp_in = rffp[RFFP_MAN_WIDTH +: RFFP_EXP_WIDTH];
  assign man    = rffp[RFFP_MAN_WIDTH-1:0];

  // Leading-zero count, exponent rebias with modulo wrap; zero flag is
  // decided from the input fields, never from the wrapped result.
  always_comb begin
    lzc = RFFP_MAN_WIDTH;
    for (int i = 0; i < RFFP_MAN_WIDTH; i++)
      if (man[i]) lzc = RFFP_MAN_WIDTH - 1 - i;
    zero     = (exp_in == '0) || (man == '0);
    exp_calc = int'(exp_in) - lzc + 1 + 128 - (1 << (EXP_WIDTH - 1));
    exp_out  = zero ? '0 : exp_calc[EXP_WIDTH-1:0];
    fp       = {sign, exp_out, man[RFFP_MAN_WIDTH-2:0]};
  end

endmodule

// File: rtl/rffp_conv_sched.sv
// Round-robin scheduler sharing one RFFP->FP core among NUM_REQ
// valid/ready requesters through a two-stage (S1 capture, S2 output) pipe.
module rffp_conv_sched
  import rffp_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int EXP_WIDTH      = 8,
  parameter int MAN_WIDTH      = 7,
  parameter int RFFP_EXP_WIDTH = 8,
  parameter int RFFP_MAN_WIDTH = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                enable,
  input  logic [NUM_REQ-1:0]                                  req_valid,
  input  logic [NUM_REQ*(1+RFFP_EXP_WIDTH+RFFP_MAN_WIDTH)-1:0] req_data,
  output logic [NUM_REQ-1:0]                                  req_ready,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]                        out_data,
  output logic [$clog2(NUM_REQ)-1:0]                          out_id,
  output logic                                                busy,
  output logic [CNT_WIDTH-1:0]                                conv_count,
  output logic [CNT_WIDTH-1:0]                                zero_count
);

  localparam int RW = 1 + RFFP_EXP_WIDTH + RFFP_MAN_WIDTH;
  localparam int FW = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int IW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [RW-1:0] rffp;
  } s1_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [FW-1:0] fp;
    logic          zero;
  } s2_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [1:0]    vld_pipe;   // [0]=S1 occupied, [1]=S2 occupied
  s1_t           s1_q;
  s2_t           s2_q;

  logic          s2_take, s1_open, any_req, accept, pipe_busy;
  logic [IW-1:0] grant, cand;
  logic [FW-1:0] conv_fp;
  logic          conv_zero;
  logic [RW-1:0] lane_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_word[g] = req_data[g*RW +: RW];
  end

  assign s2_take   = !vld_pipe[1] || out_ready;
  assign s1_open   = !vld_pipe[0] || s2_take;
  assign pipe_busy = |vld_pipe;
  assign accept    = (state == RUN) && any_req && s1_open;

  // Round-robin pick: scan from the highest offset down so the lowest
  // offset from rr_ptr with a valid request wins.
  always_comb begin
    grant   = rr_ptr;
    cand    = rr_ptr;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

  // Ready is one-hot on the granted lane, only when S1 can take it.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // Next-state logic; drain keeps completing work already accepted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = pipe_busy ? DRAIN : IDLE;
      DRAIN:   if (enable) state_nxt = RUN;
               else if (!pipe_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + IW'(1);
    end
  end

  rffp_fp_conv #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MAN_WIDTH      (MAN_WIDTH),
    .RFFP_EXP_WIDTH (RFFP_EXP_WIDTH),
    .RFFP_MAN_WIDTH (RFFP_MAN_WIDTH)
  ) u_conv (
    .rffp (s1_q.rffp),
    .fp   (conv_fp),
    .zero (conv_zero)
  );

  // Pipeline stages: S2 loads whenever its slot frees up, S1 refills
  // behind it; stalled S2 holds its word unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_open) begin
        vld_pipe[0] <= accept;
        if (accept) begin
          s1_q.id   <= grant;
          s1_q.rffp <= lane_word[grant];
        end
      end
      if (s2_take) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) begin
          s2_q.id   <= s1_q.id;
          s2_q.fp   <= conv_fp;
          s2_q.zero <= conv_zero;
        end
      end
    end
  end

  // Handshake counters, free-running with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count <= '0;
      zero_count <= '0;
    end else if (out_valid && out_ready) begin
      conv_count <= conv_count + CNT_WIDTH'(1);
      if (s2_q.zero) zero_count <= zero_count + CNT_WIDTH'(1);
    end
  end

  assign out_valid = vld_pipe[1];
  assign out_data  = s2_q.fp;
  assign out_id    = s2_q.id;
  assign busy      = (state != IDLE);

endmodule
